// File: rtl/display_pkg.sv
// Shared constants, state encoding and view lookup
// for the debug display sequencer.
package display_pkg;

  localparam int SEQ_LEN = 8;
  localparam int SEL_W   = 11;
  localparam int IDX_W   = 3;

  localparam logic [SEL_W-1:0] SEL_RF = 11'd0;
  localparam logic [SEL_W-1:0] SEL_PC = 11'd10;
  localparam logic [SEL_W-1:0] SEL_IR = 11'd11;
  localparam logic [SEL_W-1:0] SEL_RA = 11'd12;
  localparam logic [SEL_W-1:0] SEL_RB = 11'd13;
  localparam logic [SEL_W-1:0] SEL_RZ = 11'd14;
  localparam logic [SEL_W-1:0] SEL_RM = 11'd15;
  localparam logic [SEL_W-1:0] SEL_RY = 11'd16;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    HOLD   = 2'd2
  } scan_state_e;

  function automatic logic [SEL_W-1:0] idx_to_sel(
    input logic [IDX_W-1:0] idx
  );
    logic [SEL_W-1:0] sel;
    sel = SEL_RF;
    unique case (idx)
      3'd0: sel = SEL_RF;
      3'd1: sel = SEL_PC;
      3'd2: sel = SEL_IR;
      3'd3: sel = SEL_RA;
      3'd4: sel = SEL_RB;
      3'd5: sel = SEL_RZ;
      3'd6: sel = SEL_RM;
      3'd7: sel = SEL_RY;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_dwell_timer.sv
// Free-running dwell counter with clear/enable and
// a terminal-count pulse, shared with the digit scanner.
module dwell_timer #(
  parameter int CNT_W = 26,
  parameter int TERM  = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TERM - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // clear wins over enable so a manual step never double-steps
  always_comb begin
    expire = en & ~clr & (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (clr || expire) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + ONE;
    end
    tick_d = expire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// Debug display view sequencer: auto/manual stepping
// through the mux views with a hold/snapshot function.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 26
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             auto_en,
  input  logic             step_pulse,
  input  logic             back_pulse,
  input  logic             hold,
  input  logic [31:0]      hex_in,
  output logic [SEL_W-1:0] select,
  output logic [IDX_W-1:0] stage_index,
  output logic             dwell_tick,
  output logic             frozen,
  output logic [31:0]      hex_latched
);

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  scan_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [31:0]      hex_q, hex_d;

  logic holding;
  logic entering;
  logic leaving;
  logic fwd;
  logic rev;
  logic any_pulse;
  logic tmr_clr;
  logic tmr_en;
  logic tmr_exp;
  logic tmr_tick;

  dwell_timer #(
    .CNT_W (CNT_W),
    .TERM  (DWELL_CYCLES)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (reset_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_exp),
    .tick   (tmr_tick)
  );

  // mode is decided from this cycle's inputs: hold > auto_en
  always_comb begin
    state_d = MANUAL;
    if (hold) begin
      state_d = HOLD;
    end else if (auto_en) begin
      state_d = AUTO;
    end
  end

  always_comb begin
    holding   = (state_q == HOLD);
    entering  = hold & ~holding;
    leaving   = ~hold & holding;
    fwd       = step_pulse & ~back_pulse;
    rev       = back_pulse & ~step_pulse;
    any_pulse = step_pulse | back_pulse;

    tmr_en  = (state_d == AUTO);
    tmr_clr = (state_d == MANUAL) |
              (tmr_en & (any_pulse | leaving));

    idx_d = idx_q;
    if (!hold) begin
      if (fwd) begin
        idx_d = idx_q + IDX_ONE;
      end else if (rev) begin
        idx_d = idx_q - IDX_ONE;
      end else if (tmr_exp) begin
        idx_d = idx_q + IDX_ONE;
      end
    end

    sel_d = idx_to_sel(idx_d);
    hex_d = entering ? hex_in : hex_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MANUAL;
      idx_q   <= '0;
      sel_q   <= '0;
      hex_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      hex_q   <= hex_d;
    end
  end

  assign select      = sel_q;
  assign stage_index = idx_q;
  assign dwell_tick  = tmr_tick;
  assign frozen      = holding;
  assign hex_latched = hex_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl against a
// view-sequence reference model.
module tb_display_scan_ctrl;

  localparam int DW = 4;

  typedef struct {
    logic [10:0] sel;
    logic [2:0]  idx;
    logic        tick;
    logic        frz;
    logic [31:0] hx;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        auto_en = 1'b0;
  logic        step_pulse = 1'b0;
  logic        back_pulse = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] hex_in = '0;
  logic [10:0] select;
  logic [2:0]  stage_index;
  logic        dwell_tick;
  logic        frozen;
  logic [31:0] hex_latched;

  display_scan_ctrl #(
    .DWELL_CYCLES (DW),
    .CNT_W        (26)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .auto_en     (auto_en),
    .step_pulse  (step_pulse),
    .back_pulse  (back_pulse),
    .hold        (hold),
    .hex_in      (hex_in),
    .select      (select),
    .stage_index (stage_index),
    .dwell_tick  (dwell_tick),
    .frozen      (frozen),
    .hex_latched (hex_latched)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  exp_t sb[$];

  int          tbl[8] = '{0, 10, 11, 12, 13, 14, 15, 16};
  int          m_idx  = 0;
  int          m_cnt  = 0;
  bit          m_held = 0;
  logic [31:0] m_lat  = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_total++;
    if (act !== req)
      $display("FAIL %s: got %0h required %0h @%0t",
               nm, act, req, $time);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    m_idx  = 0;
    m_cnt  = 0;
    m_held = 0;
    m_lat  = '0;
  endtask

  // cycles spent on a view; hold freezes, leaving hold restarts
  task automatic model(input bit a, input bit s,
                       input bit b, input bit h,
                       input logic [31:0] hx);
    exp_t e;
    bit   tk;
    bit   leaving;
    tk = 0;
    if (h) begin
      if (!m_held) m_lat = hx;
      m_held = 1;
    end else begin
      leaving = m_held;
      m_held  = 0;
      if (s || b) begin
        m_idx = (m_idx + int'(s) - int'(b) + 8) % 8;
        m_cnt = 0;
      end else if (!a || leaving) begin
        m_cnt = 0;
      end else if (m_cnt == DW - 1) begin
        m_idx = (m_idx + 1) % 8;
        m_cnt = 0;
        tk    = 1;
      end else begin
        m_cnt++;
      end
      if (!a) m_cnt = 0;
    end
    e.sel  = 11'(tbl[m_idx]);
    e.idx  = 3'(m_idx);
    e.tick = tk;
    e.frz  = h;
    e.hx   = m_lat;
    sb.push_back(e);
  endtask

  task automatic cyc(input bit a, input bit s,
                     input bit b, input bit h,
                     input logic [31:0] hx);
    @(negedge clk);
    auto_en    = a;
    step_pulse = s;
    back_pulse = b;
    hold       = h;
    hex_in     = hx;
    model(a, s, b, h, hx);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sel"},  32'(select), 0);
    chk({tag, "_idx"},  32'(stage_index), 0);
    chk({tag, "_tick"}, 32'(dwell_tick), 0);
    chk({tag, "_frz"},  32'(frozen), 0);
    chk({tag, "_hx"},   hex_latched, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("select", 32'(select), 32'(e.sel));
        chk("stage_index", 32'(stage_index), 32'(e.idx));
        chk("dwell_tick", 32'(dwell_tick), 32'(e.tick));
        chk("frozen", 32'(frozen), 32'(e.frz));
        chk("hex_latched", hex_latched, e.hx);
      end
    end
  end

  initial begin : stim
    int hold_left;
    bit a;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;

    repeat (20) cyc(0, 0, 0, 0, $urandom);

    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 0, $urandom);
      cyc(0, 0, 0, 0, $urandom);
    end
    cyc(0, 0, 1, 0, $urandom);
    cyc(0, 1, 0, 0, $urandom);

    repeat (14) cyc(1, 0, 0, 0, $urandom);
    cyc(1, 0, 0, 0, $urandom);
    cyc(1, 0, 0, 0, $urandom);
    cyc(1, 1, 0, 0, $urandom);
    repeat (9) cyc(1, 0, 0, 0, $urandom);

    while (m_idx != 3) cyc(0, 1, 0, 0, $urandom);
    cyc(1, 0, 0, 0, $urandom);
    cyc(1, 0, 0, 1, 32'hDEADBEEF);
    for (int i = 0; i < 9; i++)
      cyc(1, i[0], 0, 1, $urandom);
    repeat (10) cyc(1, 0, 0, 0, $urandom);

    cyc(0, 1, 1, 0, $urandom);
    cyc(0, 0, 0, 0, $urandom);
    cyc(1, 0, 0, 0, $urandom);
    cyc(1, 0, 0, 0, $urandom);
    cyc(1, 1, 1, 0, $urandom);
    repeat (6) cyc(1, 0, 0, 0, $urandom);

    while (m_idx != 5) cyc(0, 1, 0, 0, $urandom);
    cyc(1, 0, 0, 0, $urandom);
    cyc(1, 0, 0, 0, $urandom);
    repeat (3) cyc(1, 0, 0, 1, $urandom);
    @(negedge clk);
    #2;
    reset_n    = 1'b0;
    auto_en    = 1'b0;
    step_pulse = 1'b0;
    back_pulse = 1'b0;
    hold       = 1'b0;
    #1;
    chk_zero("async_rst");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) cyc(0, 0, 0, 0, $urandom);
    cyc(0, 1, 0, 0, $urandom);

    hold_left = 0;
    a = 0;
    for (int i = 0; i < 3000; i++) begin
      bit h;
      if ($urandom % 50 == 0) a = ~a;
      h = 0;
      if (hold_left > 0) begin
        h = 1;
        hold_left--;
      end else if ($urandom % 40 == 0) begin
        hold_left = $urandom_range(1, 6);
      end
      cyc(a, ($urandom % 6) == 0,
          ($urandom % 9) == 0, h, $urandom);
    end

    repeat (3) @(posedge clk);
    #2;
    n_total++;
    if (sb.size() != 0)
      $display("FAIL drain: got %0d pending required 0",
               sb.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
